// File: rtl/sbp_pkg.sv
// Shared types for the SBP update issuer: command record, FSM states and field widths.
package sbp_pkg;

  localparam int STAGE_ID_BITS = 6;
  localparam int LOCATION_BITS = 11;
  localparam int PREFIX_BITS   = 32;
  localparam int LENGTH_BITS   = 6;

  typedef struct packed {
    logic [PREFIX_BITS-1:0]   prefix;
    logic [LENGTH_BITS-1:0]   length;
    logic [STAGE_ID_BITS-1:0] stage_id;
    logic [LOCATION_BITS-1:0] location;
    logic [STAGE_ID_BITS-1:0] childs_stage_id;
    logic [LOCATION_BITS-1:0] childs_location;
    logic [1:0]               childs_lr;
    logic                     last;
  } upd_cmd_t;

  typedef enum logic [1:0] {IDLE, BURST, QUANTUM} fsm_state_t;

endpackage

// File: rtl/sbp_upd_fifo.sv
// Synchronous FIFO of update commands; head visible combinationally, pop/push take effect at the clock.
// Push is dropped when full unless a pop happens in the same cycle.
module sbp_upd_fifo
  import sbp_pkg::*;
#(
  parameter int DEPTH = 64
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     push,
  input  upd_cmd_t wr_data,
  input  logic     pop,
  output upd_cmd_t rd_data,
  output logic     full,
  output logic     empty
);

  localparam int AW = $clog2(DEPTH);

  upd_cmd_t       mem [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic [AW:0]    cnt;
  logic           do_push;
  logic           do_pop;

  assign full    = (cnt == (AW+1)'(DEPTH));
  assign empty   = (cnt == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + (AW+1)'(1);
        2'b01:   cnt <= cnt - (AW+1)'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/sbp_update_issuer.sv
// Port-0 front end of the SBP pipeline: queues update groups, bursts them, muxes lookups; 1-cycle registered outputs.
// Lookups are stalled (lkp_ready_o=0) during bursts. Optional counters under SBP_UPD_STATS_EN.
module sbp_update_issuer
  import sbp_pkg::*;
#(
  parameter int FIFO_DEPTH   = 64,
  parameter int PIPE_LATENCY = 34,
  parameter int LKP_QUANTUM  = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cmd_valid_i,
  output logic                     cmd_ready_o,
  input  logic                     cmd_last_i,
  input  logic [31:0]              cmd_prefix_i,
  input  logic [5:0]               cmd_length_i,
  input  logic [STAGE_ID_BITS-1:0] cmd_stage_id_i,
  input  logic [LOCATION_BITS-1:0] cmd_location_i,
  input  logic [STAGE_ID_BITS-1:0] cmd_childs_stage_id_i,
  input  logic [LOCATION_BITS-1:0] cmd_childs_location_i,
  input  logic [1:0]               cmd_childs_lr_i,
  input  logic                     lkp_valid_i,
  output logic                     lkp_ready_o,
  input  logic [31:0]              lkp_ip_addr_i,
  output logic [31:0]              ip_addr_o,
  output logic                     lkp_valid_o,
  output logic                     upd_o,
  output logic [STAGE_ID_BITS-1:0] upd_stage_id_o,
  output logic [LOCATION_BITS-1:0] upd_location_o,
  output logic [5:0]               upd_length_o,
  output logic [STAGE_ID_BITS-1:0] upd_childs_stage_id_o,
  output logic [LOCATION_BITS-1:0] upd_childs_location_o,
  output logic [1:0]               upd_childs_lr_o,
  output logic                     grp_done_o,
`ifdef SBP_UPD_STATS_EN
  output logic [31:0]              stat_upd_cnt_o,
  output logic [31:0]              stat_grp_cnt_o,
  output logic [31:0]              stat_lkp_stall_cnt_o,
`endif
  output logic                     busy_o
);

  localparam int GW = $clog2(FIFO_DEPTH) + 1;
  localparam int QW = $clog2(LKP_QUANTUM) + 1;

  upd_cmd_t               cmd_in;
  upd_cmd_t               head;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic                   push;
  logic                   pop;
  logic                   pop_last;
  logic                   lkp_acc;
  fsm_state_t             state;
  logic [GW-1:0]          grp_cnt;
  logic [QW-1:0]          q_cnt;
  logic [PIPE_LATENCY-1:0] done_sr;

  assign cmd_in = '{prefix: cmd_prefix_i, length: cmd_length_i, stage_id: cmd_stage_id_i,
                    location: cmd_location_i, childs_stage_id: cmd_childs_stage_id_i,
                    childs_location: cmd_childs_location_i, childs_lr: cmd_childs_lr_i,
                    last: cmd_last_i};

  assign cmd_ready_o = !fifo_full;
  assign push        = cmd_valid_i && !fifo_full;
  assign lkp_ready_o = (state != BURST);
  assign lkp_acc     = lkp_valid_i && lkp_ready_o;
  assign pop         = (state == BURST) && !fifo_empty;
  assign pop_last    = pop && head.last;
  assign busy_o      = !fifo_empty || (state == BURST) || (|done_sr);

  sbp_upd_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (push),
    .wr_data (cmd_in),
    .pop     (pop),
    .rd_data (head),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state                 <= IDLE;
      grp_cnt               <= '0;
      q_cnt                 <= '0;
      done_sr               <= '0;
      grp_done_o            <= 1'b0;
      ip_addr_o             <= '0;
      lkp_valid_o           <= 1'b0;
      upd_o                 <= 1'b0;
      upd_stage_id_o        <= '0;
      upd_location_o        <= '0;
      upd_length_o          <= '0;
      upd_childs_stage_id_o <= '0;
      upd_childs_location_o <= '0;
      upd_childs_lr_o       <= '0;
    end else begin
      case ({push && cmd_last_i, pop_last})
        2'b10:   grp_cnt <= grp_cnt + GW'(1);
        2'b01:   grp_cnt <= grp_cnt - GW'(1);
        default: grp_cnt <= grp_cnt;
      endcase

      done_sr    <= {done_sr[PIPE_LATENCY-2:0], pop_last};
      grp_done_o <= done_sr[PIPE_LATENCY-1];

      if (pop) begin
        upd_o                 <= 1'b1;
        lkp_valid_o           <= 1'b0;
        ip_addr_o             <= head.prefix;
        upd_stage_id_o        <= head.stage_id;
        upd_location_o        <= head.location;
        upd_length_o          <= head.length;
        upd_childs_stage_id_o <= head.childs_stage_id;
        upd_childs_location_o <= head.childs_location;
        upd_childs_lr_o       <= head.childs_lr;
      end else begin
        upd_o                 <= 1'b0;
        lkp_valid_o           <= lkp_acc;
        ip_addr_o             <= lkp_acc ? lkp_ip_addr_i : '0;
        upd_stage_id_o        <= '0;
        upd_location_o        <= '0;
        upd_length_o          <= '0;
        upd_childs_stage_id_o <= '0;
        upd_childs_location_o <= '0;
        upd_childs_lr_o       <= '0;
      end

      // QUANTUM lasts LKP_QUANTUM-1 cycles; the IDLE cycle before the next burst supplies the last grant.
      case (state)
        IDLE: if (grp_cnt != '0 || fifo_full) state <= BURST;
        BURST: begin
          if (fifo_empty || pop_last) begin
            if (lkp_valid_i) begin
              state <= QUANTUM;
              q_cnt <= QW'(LKP_QUANTUM - 2);
            end else begin
              state <= IDLE;
            end
          end
        end
        QUANTUM: begin
          if (q_cnt == '0) state <= IDLE;
          else             q_cnt <= q_cnt - QW'(1);
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef SBP_UPD_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_upd_cnt_o       <= '0;
      stat_grp_cnt_o       <= '0;
      stat_lkp_stall_cnt_o <= '0;
    end else begin
      if (upd_o && stat_upd_cnt_o != '1)            stat_upd_cnt_o       <= stat_upd_cnt_o + 32'd1;
      if (grp_done_o && stat_grp_cnt_o != '1)       stat_grp_cnt_o       <= stat_grp_cnt_o + 32'd1;
      if (lkp_valid_i && !lkp_ready_o && stat_lkp_stall_cnt_o != '1)
        stat_lkp_stall_cnt_o <= stat_lkp_stall_cnt_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_sbp_update_issuer.sv
// Self-checking bench for sbp_update_issuer: lookup vector table, scoreboarded bursts, quantum, overflow and reset cases.
module tb_sbp_update_issuer;
  import sbp_pkg::*;

  logic                     clk = 1'b0;
  logic                     rst = 1'b1;
  logic                     cmd_valid_i = 1'b0;
  logic                     cmd_ready_o;
  upd_cmd_t                 cur_cmd = '0;
  logic                     lkp_valid_i = 1'b0;
  logic                     lkp_ready_o;
  logic [31:0]              lkp_ip_addr_i = '0;
  logic [31:0]              ip_addr_o;
  logic                     lkp_valid_o;
  logic                     upd_o;
  logic [STAGE_ID_BITS-1:0] upd_stage_id_o;
  logic [LOCATION_BITS-1:0] upd_location_o;
  logic [5:0]               upd_length_o;
  logic [STAGE_ID_BITS-1:0] upd_childs_stage_id_o;
  logic [LOCATION_BITS-1:0] upd_childs_location_o;
  logic [1:0]               upd_childs_lr_o;
  logic                     grp_done_o;
  logic                     busy_o;
`ifdef SBP_UPD_STATS_EN
  logic [31:0]              stat_upd_cnt_o;
  logic [31:0]              stat_grp_cnt_o;
  logic [31:0]              stat_lkp_stall_cnt_o;
`endif

  int n_vec = 0;
  int n_err = 0;
  upd_cmd_t    upd_q[$];
  logic [31:0] lkp_q[$];
  upd_cmd_t    mon_e;
  logic [31:0] mon_ip;

  always #5 clk = ~clk;

  sbp_update_issuer dut (
    .clk                   (clk),
    .rst                   (rst),
    .cmd_valid_i           (cmd_valid_i),
    .cmd_ready_o           (cmd_ready_o),
    .cmd_last_i            (cur_cmd.last),
    .cmd_prefix_i          (cur_cmd.prefix),
    .cmd_length_i          (cur_cmd.length),
    .cmd_stage_id_i        (cur_cmd.stage_id),
    .cmd_location_i        (cur_cmd.location),
    .cmd_childs_stage_id_i (cur_cmd.childs_stage_id),
    .cmd_childs_location_i (cur_cmd.childs_location),
    .cmd_childs_lr_i       (cur_cmd.childs_lr),
    .lkp_valid_i           (lkp_valid_i),
    .lkp_ready_o           (lkp_ready_o),
    .lkp_ip_addr_i         (lkp_ip_addr_i),
    .ip_addr_o             (ip_addr_o),
    .lkp_valid_o           (lkp_valid_o),
    .upd_o                 (upd_o),
    .upd_stage_id_o        (upd_stage_id_o),
    .upd_location_o        (upd_location_o),
    .upd_length_o          (upd_length_o),
    .upd_childs_stage_id_o (upd_childs_stage_id_o),
    .upd_childs_location_o (upd_childs_location_o),
    .upd_childs_lr_o       (upd_childs_lr_o),
    .grp_done_o            (grp_done_o),
`ifdef SBP_UPD_STATS_EN
    .stat_upd_cnt_o        (stat_upd_cnt_o),
    .stat_grp_cnt_o        (stat_grp_cnt_o),
    .stat_lkp_stall_cnt_o  (stat_lkp_stall_cnt_o),
`endif
    .busy_o                (busy_o)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Expected traffic is queued at the handshake, in acceptance order.
  always @(posedge clk) begin
    if (!rst) begin
      if (cmd_valid_i && cmd_ready_o) upd_q.push_back(cur_cmd);
      if (lkp_valid_i && lkp_ready_o) lkp_q.push_back(lkp_ip_addr_i);
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (upd_o || lkp_valid_o) check("upd_lkp_exclusive", {63'd0, upd_o & lkp_valid_o}, 64'd0);
      if (upd_o) begin
        if (upd_q.size() == 0) check("upd_unexpected", {63'd0, upd_o}, 64'd0);
        else begin
          mon_e = upd_q.pop_front();
          check("upd_prefix", {32'd0, ip_addr_o}, {32'd0, mon_e.prefix});
          check("upd_fields",
                {upd_length_o, upd_stage_id_o, upd_location_o, upd_childs_stage_id_o,
                 upd_childs_location_o, upd_childs_lr_o},
                {mon_e.length, mon_e.stage_id, mon_e.location, mon_e.childs_stage_id,
                 mon_e.childs_location, mon_e.childs_lr});
        end
      end
      if (lkp_valid_o) begin
        if (lkp_q.size() == 0) check("lkp_unexpected", {63'd0, lkp_valid_o}, 64'd0);
        else begin
          mon_ip = lkp_q.pop_front();
          check("lkp_addr", {32'd0, ip_addr_o}, {32'd0, mon_ip});
        end
      end
    end
  end

  function automatic upd_cmd_t mk(input int i, input logic last);
    upd_cmd_t c;
    c.prefix          = 32'hC0A8_0000 + 32'(i * 37);
    c.length          = 6'(i % 33);
    c.stage_id        = 6'(i);
    c.location        = 11'(i * 7);
    c.childs_stage_id = 6'(i + 1);
    c.childs_location = 11'(i * 3 + 1);
    c.childs_lr       = 2'(i);
    c.last            = last;
    return c;
  endfunction

  task automatic push_cmd(input upd_cmd_t c);
    int t;
    cur_cmd     = c;
    cmd_valid_i = 1'b1;
    t = 0;
    while (!cmd_ready_o && t < 200) begin
      @(negedge clk);
      t++;
    end
    @(negedge clk);
    cmd_valid_i = 1'b0;
  endtask

  task automatic drain(output int dones);
    dones = 0;
    for (int t = 0; t < 400; t++) begin
      @(negedge clk);
      if (grp_done_o) dones++;
      if (t > 2 && !busy_o && upd_q.size() == 0) break;
    end
    check("drain_idle", {63'd0, busy_o}, 64'd0);
    for (int t = 0; t < 3; t++) begin
      @(negedge clk);
      if (grp_done_o) dones++;
    end
  endtask

  typedef struct {
    logic        vld;
    logic [31:0] ip;
    logic        exp_vld;
    logic [31:0] exp_ip;
  } vec_t;

  initial begin
    vec_t vt[6];
    int n_upd, n_stall, n_done, first_upd, last_upd, done_at, phase, gap;

    vt[0] = '{1'b1, 32'h0A00_0001, 1'b1, 32'h0A00_0001};
    vt[1] = '{1'b1, 32'h0A00_0002, 1'b1, 32'h0A00_0002};
    vt[2] = '{1'b0, 32'hDEAD_BEEF, 1'b0, 32'h0000_0000};
    vt[3] = '{1'b1, 32'h0A00_0003, 1'b1, 32'h0A00_0003};
    vt[4] = '{1'b1, 32'h0A00_0004, 1'b1, 32'h0A00_0004};
    vt[5] = '{1'b0, 32'h0A00_0005, 1'b0, 32'h0000_0000};

    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_outputs", {ip_addr_o, 26'd0, upd_o, lkp_valid_o, grp_done_o, busy_o, upd_stage_id_o == '0, upd_location_o == '0},
          {32'd0, 26'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1});
    check("rst_readies", {62'd0, cmd_ready_o, lkp_ready_o}, 64'd3);

    // Idle lookups: registered pass-through, one cycle later.
    for (int i = 0; i < 6; i++) begin
      lkp_valid_i   = vt[i].vld;
      lkp_ip_addr_i = vt[i].ip;
      @(negedge clk);
      check("lkp_vec_valid", {63'd0, lkp_valid_o}, {63'd0, vt[i].exp_vld});
      check("lkp_vec_addr", {32'd0, ip_addr_o}, {32'd0, vt[i].exp_ip});
      check("lkp_vec_noupd", {63'd0, upd_o}, 64'd0);
    end
    lkp_valid_i = 1'b0;
    @(negedge clk);

    // Single 3-command group and its completion pulse.
    for (int i = 0; i < 3; i++) push_cmd(mk(i, i == 2));
    n_upd = 0; n_stall = 0; n_done = 0; first_upd = -1; last_upd = -1; done_at = -1;
    for (int t = 0; t < 60; t++) begin
      if (upd_o) begin
        n_upd++;
        if (first_upd < 0) first_upd = t;
        last_upd = t;
      end
      if (!lkp_ready_o) n_stall++;
      if (grp_done_o) begin
        n_done++;
        done_at = t;
      end
      @(negedge clk);
    end
    check("grp3_upd_cycles", 64'(n_upd), 64'd3);
    check("grp3_contiguous", 64'(last_upd - first_upd), 64'd2);
    check("grp3_stall_cycles", 64'(n_stall), 64'd3);
    check("grp3_done_count", 64'(n_done), 64'd1);
    check("grp3_done_latency", 64'(done_at - last_upd), 64'd34);

    // Two queued groups with lookups always pending: exactly LKP_QUANTUM lookups in between.
    phase = 0; gap = 0; n_done = 0;
    lkp_valid_i   = 1'b1;
    lkp_ip_addr_i = 32'h0B00_0000;
    fork
      begin
        for (int i = 0; i < 6; i++) push_cmd(mk(10 + i, i == 2 || i == 5));
      end
      begin
        for (int t = 0; t < 150; t++) begin
          @(negedge clk);
          if (grp_done_o) n_done++;
          case (phase)
            0: if (upd_o) phase = 1;
            1: if (!upd_o) begin phase = 2; if (lkp_valid_o) gap++; end
            2: if (upd_o) phase = 3; else if (lkp_valid_o) gap++;
            default: ;
          endcase
          lkp_ip_addr_i = lkp_ip_addr_i + 32'd1;
        end
      end
    join
    lkp_valid_i = 1'b0;
    check("quantum_second_burst", 64'(phase), 64'd3);
    check("quantum_lookups", 64'(gap), 64'd4);
    check("quantum_done_count", 64'(n_done), 64'd2);
    drain(n_done);

    // 64 commands with no last: fill, forced burst drain, no completion.
    for (int i = 0; i < 64; i++) push_cmd(mk(100 + i, 1'b0));
    check("full_ready_low", {63'd0, cmd_ready_o}, 64'd0);
    n_upd = 0; n_done = 0;
    for (int t = 0; t < 120; t++) begin
      @(negedge clk);
      if (upd_o) n_upd++;
      if (grp_done_o) n_done++;
    end
    check("full_drain_count", 64'(n_upd), 64'd64);
    check("full_no_done", 64'(n_done), 64'd0);
    check("full_idle_after", {62'd0, busy_o, cmd_ready_o}, 64'd1);

    // Reset in the middle of a 5-command burst.
    for (int i = 0; i < 5; i++) push_cmd(mk(200 + i, i == 4));
    n_upd = 0;
    for (int t = 0; t < 30 && n_upd < 2; t++) begin
      if (upd_o) n_upd++;
      if (n_upd < 2) @(negedge clk);
    end
    check("rst_mid_reached", 64'(n_upd), 64'd2);
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid_upd", {62'd0, upd_o, grp_done_o}, 64'd0);
    check("rst_mid_empty", {63'd0, busy_o}, 64'd0);
    upd_q.delete();
    lkp_q.delete();
    rst = 1'b0;
    @(negedge clk);
    check("rst_mid_readies", {62'd0, cmd_ready_o, lkp_ready_o}, 64'd3);
    n_upd = 0; n_done = 0;
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      if (upd_o) n_upd++;
      if (grp_done_o) n_done++;
    end
    check("rst_mid_no_upd", 64'(n_upd), 64'd0);
    check("rst_mid_no_done", 64'(n_done), 64'd0);

    // Two 3-command groups after reset; counters (if present) start from zero.
    for (int i = 0; i < 6; i++) push_cmd(mk(300 + i, i == 2 || i == 5));
    drain(n_done);
    check("two_grp_done_count", 64'(n_done), 64'd2);
`ifdef SBP_UPD_STATS_EN
    check("stat_upd_cnt", {32'd0, stat_upd_cnt_o}, 64'd6);
    check("stat_grp_cnt", {32'd0, stat_grp_cnt_o}, 64'd2);
`endif
    check("final_queues_empty", 64'(upd_q.size() + lkp_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, %0d miscompares so far", n_err);
    $fatal(1, "watchdog");
  end

endmodule
